kulisch_to_fp16: RTL and testbench

KULISCH_TO_FP16 -- requirements
Module: kulisch_to_fp16

---
 rtl/kulisch_to_fp16.sv | 169 ++++++++++++++++
 tb/tb_kulisch_to_fp16.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/kulisch_to_fp16.sv
// Converts a carry-save Kulisch accumulator into an IEEE-754 binary16 value
// with round-to-nearest-even, over a four-step resolve/normalise/round/output sequence.
module kulisch_to_fp16 #(
  parameter int AWIDTH = 92,
  parameter int FWIDTH = 48,
  parameter int DWIDTH = 16,
  parameter int EWIDTH = 5,
  parameter int MWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [AWIDTH-1:0] i_sum_acc,
  input  logic [AWIDTH-1:0] i_carry_acc,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DWIDTH-1:0] o_result,
  output logic              o_overflow,
  output logic              o_inexact
);

  localparam int PW      = $clog2(AWIDTH);
  localparam int BIAS    = (2 ** (EWIDTH - 1)) - 1;
  localparam int SUB_TOP = FWIDTH - BIAS;
  localparam int FW      = EWIDTH + MWIDTH;

  typedef enum logic [2:0] {IDLE, RESOLVE, NORM, ROUND, OUT} state_t;

  state_t r_state;
  state_t w_next;

  logic        [AWIDTH-1:0] r_sum_p0;
  logic        [AWIDTH-1:0] r_carry_p0;
  logic signed [AWIDTH-1:0] w_v;
  logic        [AWIDTH-1:0] w_mag;
  logic                     r_sign_p1;
  logic        [AWIDTH-1:0] r_mag_p1;
  logic        [PW-1:0]     w_lead;
  logic                     w_zero;
  logic        [PW-1:0]     r_lead_p2;
  logic                     r_zero_p2;
  logic        [PW-1:0]     w_shift;
  logic        [AWIDTH-2:0] w_frac;
  logic        [EWIDTH-1:0] w_expf;
  logic                     w_normal;
  logic                     w_big;
  logic        [FW-1:0]     w_base;
  logic                     w_guard;
  logic                     w_sticky;
  logic        [FW-1:0]     w_rounded;
  logic        [DWIDTH-1:0] w_result;
  logic                     w_ovf;
  logic                     w_inx;
  logic        [DWIDTH-1:0] r_result;
  logic                     r_ovf;
  logic                     r_inx;

  function automatic logic [FW-1:0] round_rne(input logic [FW-1:0] base,
                                              input logic guard,
                                              input logic sticky);
    return base + {{(FW-1){1'b0}}, guard & (sticky | base[0])};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_next = RESOLVE;
      RESOLVE: w_next = NORM;
      NORM:    w_next = ROUND;
      ROUND:   w_next = OUT;
      OUT:     if (o_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign i_ready = (r_state == IDLE);
  assign o_valid = (r_state == OUT);

  // p0 -> p1: resolve carry-save halves into sign and magnitude
  assign w_v   = $signed(r_sum_p0 + r_carry_p0);
  assign w_mag = w_v[AWIDTH-1] ? $unsigned(-w_v) : $unsigned(w_v);

  // p1 -> p2: leading-one search (highest set bit wins)
  always_comb begin
    w_lead = '0;
    w_zero = 1'b1;
    for (int i = 0; i < AWIDTH; i++) begin
      if (r_mag_p1[i]) begin
        w_lead = PW'(i);
        w_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && i_valid) begin
      r_sum_p0   <= i_sum_acc;
      r_carry_p0 <= i_carry_acc;
    end
    if (r_state == RESOLVE) begin
      r_sign_p1 <= w_v[AWIDTH-1];
      r_mag_p1  <= w_mag;
    end
    if (r_state == NORM) begin
      r_lead_p2 <= w_lead;
      r_zero_p2 <= w_zero;
    end
  end

  // p2 -> out: align, round, encode
  assign w_shift  = PW'(AWIDTH - 1) - r_lead_p2;
  assign w_frac   = (AWIDTH-1)'(r_mag_p1 << w_shift);
  assign w_expf   = EWIDTH'(r_lead_p2 - PW'(SUB_TOP));
  assign w_normal = (r_lead_p2 > PW'(SUB_TOP));
  assign w_big    = (r_lead_p2 > PW'(FWIDTH + BIAS));

  always_comb begin
    w_base   = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (w_normal) begin
      w_base   = {w_expf, w_frac[AWIDTH-2 -: MWIDTH]};
      w_guard  = w_frac[AWIDTH-2-MWIDTH];
      w_sticky = |w_frac[AWIDTH-3-MWIDTH:0];
    end else begin
      // Subnormal carry-out into the exponent field yields the smallest normal
      w_base   = {{EWIDTH{1'b0}}, r_mag_p1[SUB_TOP -: MWIDTH]};
      w_guard  = r_mag_p1[SUB_TOP-MWIDTH];
      w_sticky = |r_mag_p1[SUB_TOP-MWIDTH-1:0];
    end
    w_rounded = round_rne(w_base, w_guard, w_sticky);
    w_result  = '0;
    w_ovf     = 1'b0;
    w_inx     = 1'b0;
    if (r_zero_p2) begin
      w_result = '0;
    end else if (w_big || (&w_rounded[FW-1 -: EWIDTH])) begin
      w_result = {r_sign_p1, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
      w_ovf    = 1'b1;
      w_inx    = 1'b1;
    end else begin
      w_result = {r_sign_p1, w_rounded};
      w_inx    = w_guard | w_sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_inx    <= 1'b0;
    end else if (r_state == ROUND) begin
      r_result <= w_result;
      r_ovf    <= w_ovf;
      r_inx    <= w_inx;
    end
  end

  assign o_result   = r_result;
  assign o_overflow = r_ovf;
  assign o_inexact  = r_inx;

endmodule

// File: tb/tb_kulisch_to_fp16.sv
// Self-checking bench for kulisch_to_fp16: directed corner values, handshake
// and reset behaviour, then random operands against an arithmetic rounding model.
module tb_kulisch_to_fp16;
  localparam int AW = 92;
  localparam int FW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [AW-1:0] i_sum_acc;
  logic [AW-1:0] i_carry_acc;
  logic          o_valid;
  logic          o_ready;
  logic [15:0]   o_result;
  logic          o_overflow;
  logic          o_inexact;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kulisch_to_fp16 #(.AWIDTH(AW), .FWIDTH(FW), .DWIDTH(16), .EWIDTH(5), .MWIDTH(10)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_sum_acc(i_sum_acc), .i_carry_acc(i_carry_acc),
    .o_valid(o_valid), .o_ready(o_ready), .o_result(o_result),
    .o_overflow(o_overflow), .o_inexact(o_inexact)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] rnd92();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[AW-1:0];
  endfunction

  // Value = v * 2^-48; quantise to the FP16 grid whose spacing is 2^(max(e,-14)-10).
  task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] c,
                       output logic [15:0] r, output logic ovf, output logic inx);
    logic [AW-1:0] v, m, q, rem, half, one;
    logic          sgn;
    int            p, e, k, b;
    v   = s + c;
    sgn = v[AW-1];
    m   = sgn ? (~v + 1'b1) : v;
    one = 1;
    r = 16'h0000; ovf = 1'b0; inx = 1'b0;
    if (m == 0) return;
    p = 0;
    for (int i = 0; i < AW; i++) if (m[i]) p = i;
    e = p - FW;
    if (e > 15) begin
      r = {sgn, 15'h7C00}; ovf = 1'b1; inx = 1'b1;
      return;
    end
    k    = ((e < -14) ? -14 : e) - 10 + FW;
    q    = m >> k;
    rem  = m & ((one << k) - one);
    half = one << (k - 1);
    if (rem > half || (rem == half && q[0])) q = q + one;
    inx = (rem != 0);
    if (e < -14) b = int'(q[11:0]);
    else         b = (e + 15) * 1024 + int'(q[11:0]) - 1024;
    if (b >= 31744) begin
      r = {sgn, 15'h7C00}; ovf = 1'b1; inx = 1'b1;
    end else begin
      r = {sgn, b[14:0]};
    end
  endtask

  task automatic run_op(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] c,
                        input int hold);
    logic [15:0] er;
    logic        eo, ei;
    int          lat;
    model(s, c, er, eo, ei);
    @(negedge clk);
    check($sformatf("%s_ready", tag), 32'(i_ready), 32'd1);
    i_valid = 1'b1; i_sum_acc = s; i_carry_acc = c;
    @(posedge clk);
    @(negedge clk);
    i_sum_acc = rnd92(); i_carry_acc = rnd92();
    lat = 0;
    while (o_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
      i_sum_acc = rnd92(); i_carry_acc = rnd92();
    end
    check($sformatf("%s_latency", tag), 32'(lat), 32'd3);
    check($sformatf("%s_result", tag), 32'(o_result), 32'(er));
    check($sformatf("%s_ovf", tag), 32'(o_overflow), 32'(eo));
    check($sformatf("%s_inx", tag), 32'(o_inexact), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold_valid", tag), 32'(o_valid), 32'd1);
      check($sformatf("%s_hold_result", tag), 32'(o_result), 32'(er));
      check($sformatf("%s_hold_ready", tag), 32'(i_ready), 32'd0);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    check($sformatf("%s_back_ready", tag), 32'(i_ready), 32'd1);
    check($sformatf("%s_back_valid", tag), 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] one, v, cr;
    one = 1;
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    i_sum_acc = '0; i_carry_acc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    check("rst_inx", 32'(o_inexact), 32'd0);
    check("rst_ready", 32'(i_ready), 32'd1);

    run_op("one", one << 48, '0, 0);
    run_op("one_minus_ulp", one << 48, '1, 0);
    run_op("neg_1p5", ~(3 * (one << 47)) + one, '0, 0);
    run_op("tie_overflow", 65520 * (one << 48), '0, 0);
    run_op("min_sub", one << 24, '0, 0);
    run_op("sub_tie_zero", one << 23, '0, 0);
    run_op("zero", '0, '0, 0);
    run_op("neg_tiny", ~(one << 10) + one, '0, 0);
    run_op("min_neg", one << (AW - 1), '0, 0);
    run_op("hold5", 65520 * (one << 48), '0, 5);

    // Reset while the operand is in NORM
    @(negedge clk);
    i_valid = 1'b1; i_sum_acc = one << 48; i_carry_acc = '0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_result", 32'(o_result), 32'd0);
    check("midrst_ovf", 32'(o_overflow), 32'd0);
    check("midrst_inx", 32'(o_inexact), 32'd0);
    check("midrst_ready", 32'(i_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_no_valid", 32'(o_valid), 32'd0);
    run_op("after_rst", ~(3 * (one << 47)) + one, '0, 0);

    for (int n = 0; n < 150; n++) begin
      v  = rnd92() >> $urandom_range(0, AW - 1);
      if ($urandom_range(0, 1) == 1) v = ~v + one;
      cr = ($urandom_range(0, 3) == 0) ? '0 : rnd92();
      run_op($sformatf("rand%0d", n), v - cr, cr, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
